// File: rtl/decode_pkg.sv
// decode_pkg: shared constants for the decode stage.
//   imm_type_e : immediate-format codes driven on o_imm_type
//   OP_*       : 7-bit major opcodes recognised by the decoder
package decode_pkg;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/decode_pipe_imm_gen.sv
// imm_gen: combinational per-lane opcode classifier and immediate builder.
//   instr    in  32    instruction word
//   imm      out XLEN  sign-extended immediate (0 for R-type and illegal)
//   imm_type out 3     imm_type_e code (0 when illegal)
//   illegal  out 1     opcode not recognised (includes bits[1:0] != 2'b11)
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    imm_type_e t;

    always_comb begin
        t       = IMM_R;
        imm     = '0;
        illegal = 1'b0;
        // Every recognised opcode ends in 2'b11, so the full 7-bit match
        // also rejects compressed-style encodings.
        case (instr[6:0])
            OP_REG: t = IMM_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                t   = IMM_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OP_STORE: begin
                t   = IMM_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                t   = IMM_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                t   = IMM_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                t   = IMM_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                     instr[30:21], 1'b0}));
            end
            default: illegal = 1'b1;
        endcase
    end

    assign imm_type = t;

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: one registered decode stage for LANES instructions per cycle.
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_valid / o_ready    upstream handshake (o_ready = !o_valid || i_ready)
//   i_lane_en, i_instr   lane mask and instruction words (lane 0 in [31:0])
//   i_kill               flush held and incoming bundle
//   o_valid / i_ready    downstream handshake
//   o_lane_en, o_drd, o_drs1, o_drs2, o_funct3, o_funct7, o_imm,
//   o_imm_type, o_illegal  registered per-lane decode results
module decode_pipe
    import decode_pkg::*;
#(
    parameter int LANES = 1,
    parameter int XLEN  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [LANES-1:0]      i_lane_en,
    input  logic [32*LANES-1:0]   i_instr,
    input  logic                  i_kill,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LANES-1:0]      o_lane_en,
    output logic [5*LANES-1:0]    o_drd,
    output logic [5*LANES-1:0]    o_drs1,
    output logic [5*LANES-1:0]    o_drs2,
    output logic [3*LANES-1:0]    o_funct3,
    output logic [7*LANES-1:0]    o_funct7,
    output logic [XLEN*LANES-1:0] o_imm,
    output logic [3*LANES-1:0]    o_imm_type,
    output logic [LANES-1:0]      o_illegal
);

    logic [XLEN*LANES-1:0] gen_imm;
    logic [3*LANES-1:0]    gen_type;
    logic [LANES-1:0]      gen_ill;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        imm_gen #(.XLEN(XLEN)) u_imm_gen (
            .instr    (i_instr[32*g +: 32]),
            .imm      (gen_imm[XLEN*g +: XLEN]),
            .imm_type (gen_type[3*g +: 3]),
            .illegal  (gen_ill[g])
        );
    end

    logic [5*LANES-1:0]    d_drd, d_drs1, d_drs2;
    logic [3*LANES-1:0]    d_funct3, d_type;
    logic [7*LANES-1:0]    d_funct7;
    logic [XLEN*LANES-1:0] d_imm;
    logic [LANES-1:0]      d_ill;

    // Field zeroing per format; disabled or illegal lanes are all-zero.
    always_comb begin
        d_drd    = '0;
        d_drs1   = '0;
        d_drs2   = '0;
        d_funct3 = '0;
        d_funct7 = '0;
        d_imm    = '0;
        d_type   = '0;
        d_ill    = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (i_lane_en[l]) begin
                d_ill[l] = gen_ill[l];
                if (!gen_ill[l]) begin
                    d_imm[XLEN*l +: XLEN] = gen_imm[XLEN*l +: XLEN];
                    d_type[3*l +: 3]      = gen_type[3*l +: 3];
                    d_drd[5*l +: 5]       = i_instr[32*l+7  +: 5];
                    d_drs1[5*l +: 5]      = i_instr[32*l+15 +: 5];
                    d_drs2[5*l +: 5]      = i_instr[32*l+20 +: 5];
                    d_funct3[3*l +: 3]    = i_instr[32*l+12 +: 3];
                    case (gen_type[3*l +: 3])
                        IMM_R: d_funct7[7*l +: 7] = i_instr[32*l+25 +: 7];
                        IMM_I: d_drs2[5*l +: 5] = '0;
                        IMM_S, IMM_B: d_drd[5*l +: 5] = '0;
                        default: begin
                            d_funct3[3*l +: 3] = '0;
                            d_drs1[5*l +: 5]   = '0;
                            d_drs2[5*l +: 5]   = '0;
                        end
                    endcase
                end
            end
        end
    end

    logic take_in;

    assign o_ready = !o_valid || i_ready;
    assign take_in = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_lane_en  <= '0;
            o_drd      <= '0;
            o_drs1     <= '0;
            o_drs2     <= '0;
            o_funct3   <= '0;
            o_funct7   <= '0;
            o_imm      <= '0;
            o_imm_type <= '0;
            o_illegal  <= '0;
        end else if (i_kill) begin
            o_valid <= 1'b0;
        end else if (take_in) begin
            o_valid    <= 1'b1;
            o_lane_en  <= i_lane_en;
            o_drd      <= d_drd;
            o_drs1     <= d_drs1;
            o_drs2     <= d_drs2;
            o_funct3   <= d_funct3;
            o_funct7   <= d_funct7;
            o_imm      <= d_imm;
            o_imm_type <= d_type;
            o_illegal  <= d_ill;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
